// File: rtl/ram_2p_ctrl.sv
// ============================================================================
// Module  : ram_2p_ctrl
// Purpose : Two-port bus front end for a 32-bit true dual-port RAM. It decodes
//           the address range, arbitrates same-word collisions and
//           forces port B through after repeated stalls.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_2p_ctrl #(
    parameter int          SIZE      = 4096,
    parameter int          AW        = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_STALL = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          a_req_i,
    input  logic [31:0]   a_addr_i,
    input  logic          a_we_i,
    input  logic [3:0]    a_be_i,
    input  logic [31:0]   a_wdata_i,
    output logic          a_gnt_o,
    output logic          a_rvalid_o,
    output logic          a_err_o,
    output logic [31:0]   a_rdata_o,

    input  logic          b_req_i,
    input  logic [31:0]   b_addr_i,
    input  logic          b_we_i,
    input  logic [3:0]    b_be_i,
    input  logic [31:0]   b_wdata_i,
    output logic          b_gnt_o,
    output logic          b_rvalid_o,
    output logic          b_err_o,
    output logic [31:0]   b_rdata_o,

    output logic [AW-1:0] ram_a_addr_o,
    output logic          ram_a_valid_o,
    output logic [3:0]    ram_a_we_o,
    output logic [31:0]   ram_a_data_o,
    input  logic [31:0]   ram_a_data_i,

    output logic [AW-1:0] ram_b_addr_o,
    output logic          ram_b_valid_o,
    output logic [3:0]    ram_b_we_o,
    output logic [31:0]   ram_b_data_o,
    input  logic [31:0]   ram_b_data_i
);

    // offset < 4*SIZE is the same test as offset[31:2] < SIZE
    localparam logic [31:0]   c_size_bytes = 32'(SIZE * 4);
    localparam logic [3:0]    c_max_stall  = 4'(MAX_STALL);
    localparam logic [AW-1:0] c_addr_flip  = AW'(1);

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] stall_q, stall_d;

    logic       a_rvalid_q, a_err_q;
    logic       b_rvalid_q, b_err_q;

    logic [31:0]   w_a_offset, w_b_offset;
    logic          w_a_inrange, w_b_inrange;
    logic [AW-1:0] w_a_word, w_b_word;
    logic          w_collision;

    assign w_a_offset  = a_addr_i - BASE_ADDR;
    assign w_b_offset  = b_addr_i - BASE_ADDR;
    assign w_a_inrange = (a_addr_i >= BASE_ADDR) && (w_a_offset < c_size_bytes);
    assign w_b_inrange = (b_addr_i >= BASE_ADDR) && (w_b_offset < c_size_bytes);
    assign w_a_word    = w_a_offset[AW+1:2];
    assign w_b_word    = w_b_offset[AW+1:2];

    // Grants are suppressed while reset is asserted, independent of the clock
    assign a_gnt_o       = a_req_i && (state_q == NORMAL) && !rst_i;
    assign ram_a_valid_o = a_gnt_o && w_a_inrange;
    assign ram_a_we_o    = (ram_a_valid_o && a_we_i) ? a_be_i : 4'b0000;
    assign ram_a_data_o  = a_wdata_i;

    assign w_collision   = b_req_i && w_b_inrange && ram_a_valid_o
                           && (w_a_word == w_b_word);

    assign b_gnt_o       = b_req_i && !w_collision && !rst_i;
    assign ram_b_valid_o = b_gnt_o && w_b_inrange;
    assign ram_b_we_o    = (ram_b_valid_o && b_we_i) ? b_be_i : 4'b0000;
    assign ram_b_data_o  = b_wdata_i;

    // Idle port A is parked on a different word than port B
    assign ram_b_addr_o  = w_b_word;
    assign ram_a_addr_o  = ram_a_valid_o ? w_a_word : (w_b_word ^ c_addr_flip);

    always_comb begin
        state_d = state_q;
        stall_d = 4'd0;
        if (w_collision) begin
            stall_d = stall_q + 4'd1;
        end
        if (state_q == FORCE_B) begin
            state_d = NORMAL;
        end else if (stall_d == c_max_stall) begin
            state_d = FORCE_B;
            stall_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= NORMAL;
            stall_q    <= 4'd0;
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            a_rvalid_q <= a_gnt_o;
            a_err_q    <= a_gnt_o && !w_a_inrange;
            b_rvalid_q <= b_gnt_o;
            b_err_q    <= b_gnt_o && !w_b_inrange;
        end
    end

    assign a_rvalid_o = a_rvalid_q;
    assign a_err_o    = a_rvalid_q && a_err_q;
    assign a_rdata_o  = (a_rvalid_q && !a_err_q) ? ram_a_data_i : 32'h0;

    assign b_rvalid_o = b_rvalid_q;
    assign b_err_o    = b_rvalid_q && b_err_q;
    assign b_rdata_o  = (b_rvalid_q && !b_err_q) ? ram_b_data_i : 32'h0;

endmodule

`default_nettype wire
